// File: rtl/ctrl_field.sv
// ctrl_field: CAN base-format control-field transmitter (IDE, r0, DLC[3:0]).
// Starts on the RTR stage's completion pulse and serialises the field MSB first.
// Each field bit advances only on a qualified sample point; stuff-bit times stall it.
// On completion it pulses the data-field stage and forwards the captured frame
// type and the decoded payload byte count.
`timescale 1ns/1ps

module ctrl_field #(
   parameter int MAX_BYTES = 8
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       enable,
   input  logic       sample_point,
   input  logic       stuff_bit_inserted,
   input  logic       rtr_complete,
   input  logic       frame_type_in,
   input  logic [3:0] dlc_in,
   output logic       ctrl_bit,
   output logic       ctrl_complete,
   output logic       frame_type_out,
   output logic [3:0] data_bytes
);

   typedef enum logic [1:0] {
      ST_IDLE     = 2'b00,
      ST_SHIFT    = 2'b01,
      ST_COMPLETE = 2'b10
   } state_t;

   // Payload ceiling folded into the 4-bit width of data_bytes.
   localparam logic [3:0] MAX_BYTES_C = (MAX_BYTES > 15) ? 4'd15 : 4'(MAX_BYTES);

   // Index of the last field bit (DLC0); the following advance ends the field.
   localparam logic [2:0] LAST_CNT_C = 3'd5;

   // Remote frames carry no payload; data frames saturate DLC at the ceiling.
   function automatic logic [3:0] payload_bytes(input logic ft, input logic [3:0] dlc);
      logic [3:0] res;
      if (ft) begin
         res = 4'd0;
      end else if (dlc > MAX_BYTES_C) begin
         res = MAX_BYTES_C;
      end else begin
         res = dlc;
      end
      return res;
   endfunction

   state_t     state_r,          state_nxt_s;
   logic       ctrl_bit_r,       ctrl_bit_nxt_s;
   logic       ctrl_complete_r,  ctrl_complete_nxt_s;
   logic       frame_type_r,     frame_type_nxt_s;
   logic [3:0] data_bytes_r,     data_bytes_nxt_s;
   logic [2:0] bit_cnt_r,        bit_cnt_nxt_s;
   logic [4:0] shift_r,          shift_nxt_s;
   logic       advance_s;

   // A stuff-bit time never consumes a control-field bit.
   assign advance_s = sample_point & ~stuff_bit_inserted;

   // Next-state and next-output logic; every register holds unless told otherwise.
   always_comb begin
      state_nxt_s         = state_r;
      ctrl_bit_nxt_s      = ctrl_bit_r;
      ctrl_complete_nxt_s = ctrl_complete_r;
      frame_type_nxt_s    = frame_type_r;
      data_bytes_nxt_s    = data_bytes_r;
      bit_cnt_nxt_s       = bit_cnt_r;
      shift_nxt_s         = shift_r;

      if (!enable) begin
         state_nxt_s         = ST_IDLE;
         ctrl_bit_nxt_s      = 1'b1;
         ctrl_complete_nxt_s = 1'b0;
         frame_type_nxt_s    = 1'b0;
         data_bytes_nxt_s    = 4'd0;
         bit_cnt_nxt_s       = 3'd0;
         shift_nxt_s         = 5'd0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               ctrl_bit_nxt_s      = 1'b1;
               ctrl_complete_nxt_s = 1'b0;
               if (rtr_complete) begin
                  // IDE (dominant) goes out right away; r0 and DLC wait in the shifter.
                  state_nxt_s      = ST_SHIFT;
                  ctrl_bit_nxt_s   = 1'b0;
                  shift_nxt_s      = {1'b0, dlc_in};
                  bit_cnt_nxt_s    = 3'd0;
                  frame_type_nxt_s = frame_type_in;
                  data_bytes_nxt_s = payload_bytes(frame_type_in, dlc_in);
               end else begin
                  state_nxt_s = ST_IDLE;
               end
            end

            ST_SHIFT: begin
               if (advance_s) begin
                  if (bit_cnt_r < LAST_CNT_C) begin
                     ctrl_bit_nxt_s = shift_r[4];
                     shift_nxt_s    = {shift_r[3:0], 1'b0};
                     bit_cnt_nxt_s  = bit_cnt_r + 3'd1;
                  end else begin
                     // DLC0 has been sampled: release the bus and notify downstream.
                     state_nxt_s         = ST_COMPLETE;
                     ctrl_bit_nxt_s      = 1'b1;
                     ctrl_complete_nxt_s = 1'b1;
                  end
               end else begin
                  state_nxt_s = ST_SHIFT;
               end
            end

            ST_COMPLETE: begin
               // Single-cycle completion pulse; a start seen here is not accepted.
               state_nxt_s         = ST_IDLE;
               ctrl_bit_nxt_s      = 1'b1;
               ctrl_complete_nxt_s = 1'b0;
            end

            default: begin
               state_nxt_s         = ST_IDLE;
               ctrl_bit_nxt_s      = 1'b1;
               ctrl_complete_nxt_s = 1'b0;
               frame_type_nxt_s    = 1'b0;
               data_bytes_nxt_s    = 4'd0;
               bit_cnt_nxt_s       = 3'd0;
               shift_nxt_s         = 5'd0;
            end
         endcase
      end
   end

   // State and output registers with asynchronous reset to the idle values.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_r         <= ST_IDLE;
         ctrl_bit_r      <= 1'b1;
         ctrl_complete_r <= 1'b0;
         frame_type_r    <= 1'b0;
         data_bytes_r    <= 4'd0;
         bit_cnt_r       <= 3'd0;
         shift_r         <= 5'd0;
      end else begin
         state_r         <= state_nxt_s;
         ctrl_bit_r      <= ctrl_bit_nxt_s;
         ctrl_complete_r <= ctrl_complete_nxt_s;
         frame_type_r    <= frame_type_nxt_s;
         data_bytes_r    <= data_bytes_nxt_s;
         bit_cnt_r       <= bit_cnt_nxt_s;
         shift_r         <= shift_nxt_s;
      end
   end

   assign ctrl_bit       = ctrl_bit_r;
   assign ctrl_complete  = ctrl_complete_r;
   assign frame_type_out = frame_type_r;
   assign data_bytes     = data_bytes_r;

   ctrl_field_chk u_chk (
      .clock         (clock),
      .reset         (reset),
      .ctrl_bit      (ctrl_bit_r),
      .ctrl_complete (ctrl_complete_r),
      .bit_cnt       (bit_cnt_r),
      .state         (state_r)
   );

endmodule

// ctrl_field_chk: structural invariants of the control-field transmitter.
module ctrl_field_chk (
   input logic       clock,
   input logic       reset,
   input logic       ctrl_bit,
   input logic       ctrl_complete,
   input logic [2:0] bit_cnt,
   input logic [1:0] state
);

   // The bit counter stops at DLC0 and never wraps.
   a_cnt_range: assert property (@(posedge clock) disable iff (reset)
      bit_cnt <= 3'd5);

   // Completion is a one-cycle pulse.
   a_pulse: assert property (@(posedge clock) disable iff (reset)
      ctrl_complete |=> !ctrl_complete);

   // The bus is recessive while completion is signalled.
   a_recessive: assert property (@(posedge clock) disable iff (reset)
      ctrl_complete |-> ctrl_bit);

   // The unused state encoding is never reached.
   a_legal_state: assert property (@(posedge clock) disable iff (reset)
      state != 2'b11);

endmodule

// File: tb/tb_ctrl_field.sv
// tb_ctrl_field: table-driven check of the control-field transmitter plus
// hand-written stall, abort, reset and spurious-start sequences.
`timescale 1ns/1ps

module tb_ctrl_field;

   logic       clock;
   logic       reset;
   logic       enable;
   logic       sample_point;
   logic       stuff_bit_inserted;
   logic       rtr_complete;
   logic       frame_type_in;
   logic [3:0] dlc_in;
   logic       ctrl_bit;
   logic       ctrl_complete;
   logic       frame_type_out;
   logic [3:0] data_bytes;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic       ft;
      logic [3:0] dlc;
      logic [5:0] bits;   // expected wire order IDE..DLC0, MSB first
      logic [3:0] bytes;
   } vec_t;

   vec_t vecs[7];

   ctrl_field #(.MAX_BYTES(8)) dut (
      .clock              (clock),
      .reset              (reset),
      .enable             (enable),
      .sample_point       (sample_point),
      .stuff_bit_inserted (stuff_bit_inserted),
      .rtr_complete       (rtr_complete),
      .frame_type_in      (frame_type_in),
      .dlc_in             (dlc_in),
      .ctrl_bit           (ctrl_bit),
      .ctrl_complete      (ctrl_complete),
      .frame_type_out     (frame_type_out),
      .data_bytes         (data_bytes)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic adv(input logic stuff);
      sample_point       = 1'b1;
      stuff_bit_inserted = stuff;
      tick();
      sample_point       = 1'b0;
      stuff_bit_inserted = 1'b0;
   endtask

   task automatic start(input logic ft, input logic [3:0] dlc);
      frame_type_in = ft;
      dlc_in        = dlc;
      rtr_complete  = 1'b1;
      tick();
      rtr_complete  = 1'b0;
   endtask

   task automatic run_field(input vec_t v, input int idx);
      chk($sformatf("v%0d_idle_bit", idx), {3'd0, ctrl_bit}, 4'd1);
      start(v.ft, v.dlc);
      chk($sformatf("v%0d_ide", idx), {3'd0, ctrl_bit}, {3'd0, v.bits[5]});
      chk($sformatf("v%0d_bytes", idx), data_bytes, v.bytes);
      chk($sformatf("v%0d_ft", idx), {3'd0, frame_type_out}, {3'd0, v.ft});
      for (int k = 1; k < 6; k++) begin
         adv(1'b0);
         chk($sformatf("v%0d_bit%0d", idx, k), {3'd0, ctrl_bit}, {3'd0, v.bits[5-k]});
         chk($sformatf("v%0d_nocmp%0d", idx, k), {3'd0, ctrl_complete}, 4'd0);
         tick();
         chk($sformatf("v%0d_hold%0d", idx, k), {3'd0, ctrl_bit}, {3'd0, v.bits[5-k]});
      end
      adv(1'b0);
      chk($sformatf("v%0d_cmp", idx), {3'd0, ctrl_complete}, 4'd1);
      chk($sformatf("v%0d_cmp_bit", idx), {3'd0, ctrl_bit}, 4'd1);
      tick();
      chk($sformatf("v%0d_cmp_end", idx), {3'd0, ctrl_complete}, 4'd0);
      chk($sformatf("v%0d_after_bit", idx), {3'd0, ctrl_bit}, 4'd1);
      chk($sformatf("v%0d_bytes_held", idx), data_bytes, v.bytes);
      chk($sformatf("v%0d_ft_held", idx), {3'd0, frame_type_out}, {3'd0, v.ft});
   endtask

   initial begin
      vecs[0] = '{ft: 1'b0, dlc: 4'd5,  bits: 6'b000101, bytes: 4'd5};
      vecs[1] = '{ft: 1'b1, dlc: 4'd3,  bits: 6'b000011, bytes: 4'd0};
      vecs[2] = '{ft: 1'b0, dlc: 4'd15, bits: 6'b001111, bytes: 4'd8};
      vecs[3] = '{ft: 1'b0, dlc: 4'd8,  bits: 6'b001000, bytes: 4'd8};
      vecs[4] = '{ft: 1'b0, dlc: 4'd0,  bits: 6'b000000, bytes: 4'd0};
      vecs[5] = '{ft: 1'b0, dlc: 4'd9,  bits: 6'b001001, bytes: 4'd8};
      vecs[6] = '{ft: 1'b1, dlc: 4'd15, bits: 6'b001111, bytes: 4'd0};

      reset              = 1'b1;
      enable             = 1'b1;
      sample_point       = 1'b0;
      stuff_bit_inserted = 1'b0;
      rtr_complete       = 1'b0;
      frame_type_in      = 1'b0;
      dlc_in             = 4'd0;
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b0;
      tick();

      // Reset state
      chk("rst_bit",   {3'd0, ctrl_bit},       4'd1);
      chk("rst_cmp",   {3'd0, ctrl_complete},  4'd0);
      chk("rst_ft",    {3'd0, frame_type_out}, 4'd0);
      chk("rst_bytes", data_bytes,             4'd0);

      // Table of complete fields
      for (int i = 0; i < 7; i++) begin
         run_field(vecs[i], i);
         tick();
      end

      // Stuffing stall during DLC2 of DLC=5 (0101)
      start(1'b0, 4'd5);
      repeat (3) adv(1'b0);
      chk("stall_dlc2", {3'd0, ctrl_bit}, 4'd1);
      for (int s = 0; s < 2; s++) begin
         adv(1'b1);
         chk($sformatf("stall_bit%0d", s), {3'd0, ctrl_bit}, 4'd1);
         chk($sformatf("stall_cnt%0d", s), {1'b0, dut.bit_cnt_r}, 4'd3);
         tick();
      end
      adv(1'b0);
      chk("stall_dlc1", {3'd0, ctrl_bit}, 4'd0);
      adv(1'b0);
      chk("stall_dlc0", {3'd0, ctrl_bit}, 4'd1);
      chk("stall_nocmp", {3'd0, ctrl_complete}, 4'd0);
      adv(1'b0);
      chk("stall_cmp", {3'd0, ctrl_complete}, 4'd1);
      tick();

      // Abort with enable low after three advances
      start(1'b0, 4'd5);
      repeat (3) adv(1'b0);
      chk("abort_pre_bytes", data_bytes, 4'd5);
      enable = 1'b0;
      tick();
      enable = 1'b1;
      chk("abort_bit",   {3'd0, ctrl_bit},      4'd1);
      chk("abort_bytes", data_bytes,            4'd0);
      chk("abort_cmp",   {3'd0, ctrl_complete}, 4'd0);
      for (int a = 0; a < 4; a++) begin
         adv(1'b0);
         chk($sformatf("abort_nocmp%0d", a), {3'd0, ctrl_complete}, 4'd0);
         chk($sformatf("abort_idle%0d", a),  {3'd0, ctrl_bit},      4'd1);
      end

      // Asynchronous reset mid-field (remote, DLC=3 -> DLC3 bit is 0)
      start(1'b1, 4'd3);
      chk("arst_ft_cap", {3'd0, frame_type_out}, 4'd1);
      repeat (2) adv(1'b0);
      chk("arst_pre_bit", {3'd0, ctrl_bit}, 4'd0);
      #2 reset = 1'b1;
      #1;
      chk("arst_bit", {3'd0, ctrl_bit},       4'd1);
      chk("arst_ft",  {3'd0, frame_type_out}, 4'd0);
      chk("arst_cnt", {1'b0, dut.bit_cnt_r},  4'd0);
      #2 reset = 1'b0;
      repeat (6) adv(1'b0);
      chk("arst_nocmp", {3'd0, ctrl_complete}, 4'd0);
      chk("arst_idle",  {3'd0, ctrl_bit},      4'd1);

      // Spurious start during SHIFT of a DLC=7 (0111) field
      start(1'b0, 4'd7);
      repeat (2) adv(1'b0);
      chk("spur_dlc3", {3'd0, ctrl_bit}, 4'd0);
      frame_type_in = 1'b1;
      dlc_in        = 4'd2;
      rtr_complete  = 1'b1;
      adv(1'b0);
      rtr_complete  = 1'b0;
      chk("spur_dlc2", {3'd0, ctrl_bit}, 4'd1);
      adv(1'b0);
      chk("spur_dlc1", {3'd0, ctrl_bit}, 4'd1);
      adv(1'b0);
      chk("spur_dlc0",  {3'd0, ctrl_bit},       4'd1);
      chk("spur_bytes", data_bytes,             4'd7);
      chk("spur_ft",    {3'd0, frame_type_out}, 4'd0);
      adv(1'b0);
      chk("spur_cmp", {3'd0, ctrl_complete}, 4'd1);
      // Start pulse on the edge that returns to IDLE is ignored
      rtr_complete = 1'b1;
      tick();
      rtr_complete = 1'b0;
      chk("late_cmp_end", {3'd0, ctrl_complete}, 4'd0);
      chk("late_bit0",    {3'd0, ctrl_bit},      4'd1);
      tick();
      chk("late_bit1",  {3'd0, ctrl_bit},       4'd1);
      chk("late_bytes", data_bytes,             4'd7);
      chk("late_ft",    {3'd0, frame_type_out}, 4'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ctrl_field.md
Name: ctrl_field

Overview:
- Control-field transmitter of the CAN data-frame builder, directly downstream of the RTR stage.
- Starts on the RTR stage's completion pulse.
- Serialises the base-format control field, MSB first: IDE (dominant 0), r0 (dominant 0), then DLC[3:0].
- Signals completion to the data-field stage and passes frame type plus the decoded payload byte count forward.

Parameters:
MAX_BYTES, 8, payload byte count ceiling applied to DLC values above it (CAN 2.0 = 8)

Ports:
clock  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-high reset
enable  input  1  low = synchronous clear to reset values (reset takes priority)
sample_point  input  1  one-cycle strobe per bit time; bit advance qualifier
stuff_bit_inserted  input  1  high = current bit time is a stuff bit; suppresses advance
rtr_complete  input  1  one-cycle start pulse from the RTR stage
frame_type_in  input  1  frame type from the RTR stage (1 = remote, 0 = data)
dlc_in  input  4  data length code to transmit
ctrl_bit  output  1  serial control-field bit to the bit stuffer/bus driver (idle recessive 1)
ctrl_complete  output  1  one-cycle pulse when the last DLC bit has been sampled
frame_type_out  output  1  captured frame type, held until next capture
data_bytes  output  4  payload byte count for the data-field stage, held until next capture

Behaviour:
- Reset/enable-low values:
  - state=IDLE, ctrl_bit=1, ctrl_complete=0, frame_type_out=0, data_bytes=0, bit_cnt=0, shift register=0.
  - Applies immediately on reset, including mid-field.
- advance = sample_point && !stuff_bit_inserted.
- States: IDLE, SHIFT, COMPLETE (2-bit encoding); any illegal encoding goes to IDLE with reset output values.
- IDLE:
  - ctrl_bit=1, ctrl_complete=0.
  - On rtr_complete: go to SHIFT. Same edge:
    - ctrl_bit<=0 (IDE).
    - shift register (5 bits) <= {1'b0 (r0), dlc_in}.
    - bit_cnt<=0.
    - frame_type_out<=frame_type_in.
    - data_bytes <= 0 if frame_type_in=1; else min(dlc_in, MAX_BYTES).
  - Latency: IDE is driven on ctrl_bit the cycle after the rtr_complete pulse.
- SHIFT:
  - On advance with bit_cnt<5: ctrl_bit<=shift register MSB, shift left by 1, bit_cnt<=bit_cnt+1.
  - On advance with bit_cnt==5: go to COMPLETE, ctrl_bit<=1, ctrl_complete<=1.
  - Without advance: all outputs hold, so a stuff-bit time never consumes a field bit.
  - Exactly 6 advances per field; bit order on ctrl_bit is IDE, r0, DLC3, DLC2, DLC1, DLC0.
- COMPLETE:
  - ctrl_complete=1 for exactly this one cycle, ctrl_bit=1.
  - Next edge: IDLE with ctrl_complete<=0.
- rtr_complete in SHIFT or COMPLETE is ignored; no restart or re-capture.
- rtr_complete on the same edge that returns to IDLE is ignored; a start is accepted only while already in IDLE.
- frame_type_out and data_bytes stay stable from capture until the next capture, reset or enable-low.
- DLC transmitted on the wire is the raw dlc_in (9-15 sent as-is); only data_bytes saturates.
- Remote frame: DLC still transmitted unchanged; data_bytes=0.
- bit_cnt is 3 bits with no wrap; it never exceeds 5.
- enable low in any state returns to IDLE with reset values on the next edge. ctrl_complete is not emitted for an aborted field.

Test Plan:
- Data frame: frame_type_in=0, dlc_in=4'd5, rtr_complete pulse, then 6 advances -> ctrl_bit sequence 0,0,0,1,0,1; data_bytes=5, frame_type_out=0; ctrl_complete high exactly one cycle after the 6th advance; ctrl_bit=1 afterwards.
- Remote frame: frame_type_in=1, dlc_in=4'd3 -> sequence 0,0,0,0,1,1; data_bytes=0; frame_type_out=1.
- Saturation: frame_type_in=0, dlc_in=4'd15 -> sequence 0,0,1,1,1,1; data_bytes=8. Then dlc_in=4'd8 -> data_bytes=8. Then dlc_in=4'd0 -> sequence 0,0,0,0,0,0; data_bytes=0.
- Stuffing stall: during DLC2, assert sample_point with stuff_bit_inserted=1 for 2 bit times -> ctrl_bit and bit_cnt unchanged. Field still completes after exactly 6 qualified advances.
- Abort: enable low after 3 advances -> next cycle IDLE, ctrl_bit=1, data_bytes=0, no ctrl_complete pulse. Assert reset asynchronously mid-SHIFT -> same values immediately.
- Spurious start: second rtr_complete with dlc_in=4'd2 during SHIFT of a DLC=7 field -> remaining bits still from DLC=7; data_bytes stays 7.
